wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter and scoreboard that owns the single register-file write port. It merges single-cycle ALU results with buffered results from long-latency units (loads, multiply) into one registered write stream. It also tracks registers with outstanding long-latency writes so decode can stall on RAW hazards. It sits between the execute/memory stages and the register file write inputs.

## Interface
- `DEPTH`, 4, slow-path FIFO entries; power of two, ≥2.
- `XLEN`, 32, data width.

- `clk` in 1: clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `alu_valid` in 1: ALU result present this cycle.
- `alu_ready` out 1: ALU result accepted; upstream holds the result while low.
- `alu_rd` in 5: ALU destination register.
- `alu_data` in XLEN: ALU result.
- `mem_valid` in 1: slow-path result offered.
- `mem_ready` out 1: FIFO can accept.
- `mem_rd` in 5: slow-path destination register.
- `mem_data` in XLEN: slow-path result.
- `issue_valid` in 1: a slow op is issued this cycle.
- `issue_rd` in 5: destination of the issued slow op.
- `chk_rs1`, `chk_rs2`, `chk_rd` in 5 each: decode operands to check.
- `stall` out 1: combinational; any checked non-zero register is pending.
- `RegWrite` out 1: register-file write enable, registered.
- `rd` out 5: register-file write address, registered.
- `WriteData` out XLEN: register-file write data, registered.
- `fifo_count` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- **FIFO:** circular, DEPTH entries of {rd, data}. The read and write pointers are $clog2(DEPTH) bits and wrap naturally.
  - Push when `mem_valid && mem_ready`.
  - `mem_ready = (fifo_count != DEPTH)`. It is based on count only, so a pop in the same cycle does not open a slot when full.
- **Arbitration (per cycle):**
  - If `fifo_count == DEPTH`, the FIFO head wins and `alu_ready = 0`.
  - Otherwise, if `alu_valid`, the ALU wins and `alu_ready = 1`.
  - Otherwise, if the FIFO is non-empty, pop the head.
  - Otherwise, idle.
  - `alu_ready` equals `fifo_count != DEPTH`, independent of `alu_valid`.
- **Write register:**
  - The winner loads `rd`/`WriteData`.
  - `RegWrite` is 1 only if a winner exists and its rd ≠ 0.
  - A winner with rd = 0 still consumes its entry; `RegWrite` stays 0 and the data is discarded.
- **Scoreboard:** 32 pending bits; bit 0 is hard-wired 0.
  - Set `pending[issue_rd]` on `issue_valid`.
  - Clear `pending[head.rd]` on FIFO pop.
  - Same register set and cleared in one cycle: set wins.
  - `stall = pending[chk_rs1] | pending[chk_rs2] | pending[chk_rd]`.
  - Issuing to an already-pending rd is illegal; decode must honour `stall`.
- **Simultaneous push and pop:** count unchanged, both pointers advance.
- **Reset (asynchronous, any time):**
  - FIFO is emptied and pointers go to 0.
  - All pending bits clear.
  - `RegWrite = 0`, `rd = 0`, `WriteData = 0`, `fifo_count = 0`.
  - `mem_ready = 1` and `alu_ready = 1` while and after reset.
  - In-flight entries are lost.

## Timing
- ALU: `alu_valid` at cycle N → `RegWrite` at N+1; the register file captures it at the end of N+1.
- Slow path: push at N → earliest `RegWrite` at N+2, when the FIFO was empty and no ALU competes.
- `fifo_count` updates at the edge after push/pop.
- `pending` is set at the edge after `issue_valid`. `stall` for that rd therefore rises at N+1 and falls the cycle after its pop edge.
- `mem_ready`, `alu_ready` and `stall` are combinational from state and inputs; there is no combinational path from `mem_valid` to `mem_ready`.

## Configuration
- `WB_BYPASS_EN` defined adds outputs `byp_hit1`, `byp_hit2` (1 bit each) and `byp_data` (XLEN).
  - `byp_hit1 = RegWrite && rd == chk_rs1 && rd != 0`; `byp_hit2` likewise for `chk_rs2`.
  - `byp_data = WriteData`.
  - Decode muxes these over register-file read data to cover same-cycle write/read.
- Undefined: these ports and their logic are absent. Decode must stall one extra cycle on a matching write.

## Test plan
- **Reset:** `rst_n = 0` mid-stream with 3 FIFO entries and `pending[5] = 1`.
  - Immediately: `fifo_count = 0`, `RegWrite = 0`, `mem_ready = 1`.
  - After release: `stall = 0` for `chk_rs1 = 5`.
- **ALU path:** `alu_valid`, `alu_rd = 7`, `alu_data = 0xDEADBEEF` at N → N+1 `RegWrite = 1`, `rd = 7`, `WriteData = 0xDEADBEEF`. `alu_rd = 0` → `RegWrite = 0`.
- **Slow path and scoreboard:**
  - `issue_valid`, `issue_rd = 9` → `stall = 1` with `chk_rs2 = 9`.
  - Push (9, 0x1234) with ALU idle → `RegWrite` with rd = 9 two cycles after the push.
  - `stall = 0` the cycle after the pop.
- **Priority and full FIFO (DEPTH = 4):**
  - Continuous `alu_valid` plus 4 pushes → `mem_ready = 0` and `alu_ready = 0`.
  - The head is written next, then `alu_ready` returns to 1.
  - Writes appear in FIFO order with no loss.
- **Set/clear collision:** pop of rd = 3 in the same cycle as `issue_rd = 3` → `pending[3]` stays 1.
- **Bypass (`WB_BYPASS_EN`):** `RegWrite = 1`, `rd = 4`, `WriteData = 0x55` with `chk_rs1 = 4` → `byp_hit1 = 1`, `byp_data = 0x55`. With `chk_rs1 = 0` → `byp_hit1 = 0`.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus bundle: ALU result, slow-path result, issue/check ports, regfile write.
// slave = arbiter side, master = execute/decode side driving results and operands.
// Optional WB_BYPASS_EN adds byp_hit1/byp_hit2/byp_data for same-cycle write/read forwarding.
interface wb_arbiter_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic            alu_valid;
   logic            alu_ready;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            mem_valid;
   logic            mem_ready;
   logic [4:0]      mem_rd;
   logic [XLEN-1:0] mem_data;
   logic            issue_valid;
   logic [4:0]      issue_rd;
   logic [4:0]      chk_rs1;
   logic [4:0]      chk_rs2;
   logic [4:0]      chk_rd;
   logic            stall;
   logic            RegWrite;
   logic [4:0]      rd;
   logic [XLEN-1:0] WriteData;
   logic [CW-1:0]   fifo_count;
`ifdef WB_BYPASS_EN
   logic            byp_hit1;
   logic            byp_hit2;
   logic [XLEN-1:0] byp_data;
`endif

   modport slave (
`ifdef WB_BYPASS_EN
      output byp_hit1, byp_hit2, byp_data,
`endif
      input  alu_valid, alu_rd, alu_data,
      input  mem_valid, mem_rd, mem_data,
      input  issue_valid, issue_rd, chk_rs1, chk_rs2, chk_rd,
      output alu_ready, mem_ready, stall, RegWrite, rd, WriteData, fifo_count
   );

   modport master (
`ifdef WB_BYPASS_EN
      input  byp_hit1, byp_hit2, byp_data,
`endif
      output alu_valid, alu_rd, alu_data,
      output mem_valid, mem_rd, mem_data,
      output issue_valid, issue_rd, chk_rs1, chk_rs2, chk_rd,
      input  alu_ready, mem_ready, stall, RegWrite, rd, WriteData, fifo_count
   );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and FIFO-buffered slow results onto the single regfile write port, plus RAW scoreboard.
// Latency: ALU 1 cycle to RegWrite; slow path >= 2 cycles (push edge, then pop/write edge).
// Backpressure: alu_ready/mem_ready both drop only when the FIFO is full; full FIFO forces a head pop.
// Ports: clk, rst_n (async active-low), bus (wb_arbiter_if.slave). Macro WB_BYPASS_EN adds forwarding outputs.
module wb_arbiter #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   wb_arbiter_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [4:0]      q_rd   [DEPTH];
   logic [XLEN-1:0] q_data [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [31:0]     pending;
   logic [31:0]     pend_nxt;

   logic            full;
   logic            push;
   logic            pop;
   logic            alu_win;
   logic            win_vld;
   logic [4:0]      win_rd;
   logic [XLEN-1:0] win_data;
   logic [4:0]      head_rd;
   logic [XLEN-1:0] head_data;

   logic            reg_write;
   logic [4:0]      rd_q;
   logic [XLEN-1:0] wdata_q;

   // Readiness depends on occupancy only, so a same-cycle pop never frees a slot
   // and there is no mem_valid -> mem_ready path.
   assign full          = (count == FULL_CNT);
   assign bus.mem_ready = ~full;
   assign bus.alu_ready = ~full;

   assign push    = bus.mem_valid & ~full;
   assign alu_win = bus.alu_valid & ~full;
   // Full FIFO always drains its head; otherwise the head only goes when the ALU is quiet.
   assign pop     = full | (~bus.alu_valid & (count != '0));
   assign win_vld = pop | alu_win;

   assign head_rd   = q_rd[rd_ptr];
   assign head_data = q_data[rd_ptr];
   assign win_rd    = pop ? head_rd   : bus.alu_rd;
   assign win_data  = pop ? head_data : bus.alu_data;

   // Clear before set so an issue to the register being retired this cycle stays pending.
   always_comb begin
      pend_nxt = pending;
      if (pop)
         pend_nxt[head_rd] = 1'b0;
      if (bus.issue_valid)
         pend_nxt[bus.issue_rd] = 1'b1;
      pend_nxt[0] = 1'b0;
   end

   assign bus.stall = pending[bus.chk_rs1] | pending[bus.chk_rs2] | pending[bus.chk_rd];

   // Storage needs no reset: contents are only observed behind a valid count.
   always_ff @(posedge clk) begin
      if (push) begin
         q_rd[wr_ptr]   <= bus.mem_rd;
         q_data[wr_ptr] <= bus.mem_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         pending   <= '0;
         reg_write <= 1'b0;
         rd_q      <= '0;
         wdata_q   <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         pending <= pend_nxt;
         // An rd=0 winner still consumes its slot; only the enable is suppressed.
         reg_write <= win_vld & (win_rd != 5'd0);
         if (win_vld) begin
            rd_q    <= win_rd;
            wdata_q <= win_data;
         end
      end
   end

   assign bus.RegWrite   = reg_write;
   assign bus.rd         = rd_q;
   assign bus.WriteData  = wdata_q;
   assign bus.fifo_count = count;

`ifdef WB_BYPASS_EN
   assign bus.byp_hit1 = reg_write & (rd_q == bus.chk_rs1) & (rd_q != 5'd0);
   assign bus.byp_hit2 = reg_write & (rd_q == bus.chk_rs2) & (rd_q != 5'd0);
   assign bus.byp_data = wdata_q;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: queue-based reference model plus negedge monitor scoreboard.
// Directed scenarios (reset, ALU, slow path, full FIFO, set/clear collision, bypass) then random traffic.
module tb_wb_arbiter;
   localparam int DEPTH = 4;
   localparam int XLEN  = 32;
   localparam int CW    = 3;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   wb_arbiter_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();
   wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   wr_t        exp_q[$];
   ent_t       mq[$];
   logic [4:0] inflight[$];
   bit [31:0]  pend;
   bit         alu_hold, mem_hold;
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;

   bit            st_vld = 1'b0;
   int            st_cyc;
   logic [CW-1:0] st_count;
   logic          st_rdy;
   logic          st_stall;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
      end
   endtask

   task automatic idle();
      bus.alu_valid   = 1'b0;
      bus.alu_rd      = '0;
      bus.alu_data    = '0;
      bus.mem_valid   = 1'b0;
      bus.mem_rd      = '0;
      bus.mem_data    = '0;
      bus.issue_valid = 1'b0;
      bus.issue_rd    = '0;
      bus.chk_rs1     = '0;
      bus.chk_rs2     = '0;
      bus.chk_rd      = '0;
   endtask

   task automatic model_reset();
      mq.delete();
      exp_q.delete();
      inflight.delete();
      pend     = '0;
      alu_hold = 1'b0;
      mem_hold = 1'b0;
      st_vld   = 1'b0;
   endtask

   // Called at posedge+1 with inputs set: records expected status for this cycle,
   // applies the arbitration rules to the model, and advances one clock.
   task automatic step();
      bit          full, wv, popd;
      ent_t        h;
      logic [4:0]  wrd;
      logic [31:0] wdat;
      full     = (mq.size() == DEPTH);
      st_count = CW'(mq.size());
      st_rdy   = !full;
      st_stall = pend[bus.chk_rs1] | pend[bus.chk_rs2] | pend[bus.chk_rd];
      st_cyc   = cyc;
      st_vld   = 1'b1;
      wv = 1'b0; popd = 1'b0; wrd = '0; wdat = '0;
      if (full || (!bus.alu_valid && mq.size() > 0)) begin
         h = mq.pop_front();
         wv = 1'b1; popd = 1'b1; wrd = h.rd; wdat = h.data;
      end else if (bus.alu_valid) begin
         wv = 1'b1; wrd = bus.alu_rd; wdat = bus.alu_data;
      end
      if (wv && wrd != 5'd0)
         exp_q.push_back('{rd: wrd, data: wdat, cyc: cyc + 1});
      if (bus.mem_valid && !full)
         mq.push_back('{rd: bus.mem_rd, data: bus.mem_data});
      if (popd) pend[wrd] = 1'b0;
      if (bus.issue_valid) pend[bus.issue_rd] = 1'b1;
      pend[0]  = 1'b0;
      alu_hold = bus.alu_valid && full;
      mem_hold = bus.mem_valid && full;
      @(posedge clk);
      #1;
   endtask

   // Monitor: every write the DUT presents must be the next expected one, in the expected cycle.
   bit  m_erw;
   wr_t m_e;
   always @(negedge clk) begin
      if (rst_n) begin
         m_erw = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
         chk("regwrite", bus.RegWrite, m_erw);
         if (m_erw) begin
            m_e = exp_q.pop_front();
            if (bus.RegWrite) begin
               chk("wr_rd", bus.rd, m_e.rd);
               chk("wr_data", bus.WriteData, m_e.data);
            end
         end
`ifdef WB_BYPASS_EN
         chk("byp_hit1", bus.byp_hit1, m_erw && (m_e.rd == bus.chk_rs1));
         chk("byp_hit2", bus.byp_hit2, m_erw && (m_e.rd == bus.chk_rs2));
         if (m_erw) chk("byp_data", bus.byp_data, m_e.data);
`endif
         if (st_vld && st_cyc == cyc) begin
            chk("fifo_count", bus.fifo_count, st_count);
            chk("alu_ready", bus.alu_ready, st_rdy);
            chk("mem_ready", bus.mem_ready, st_rdy);
            chk("stall", bus.stall, st_stall);
         end
      end
   end

   initial begin
      logic [4:0] r;
      idle();
      model_reset();
      #1 rst_n = 1'b0;
      #1;
      chk("rst_fifo_count", bus.fifo_count, 0);
      chk("rst_regwrite", bus.RegWrite, 0);
      chk("rst_rd", bus.rd, 0);
      chk("rst_wdata", bus.WriteData, 0);
      chk("rst_mem_ready", bus.mem_ready, 1);
      chk("rst_alu_ready", bus.alu_ready, 1);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ALU path, then rd=0 discard
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'hDEADBEEF;
      step();
      idle();
      #1;
      chk("alu7_regwrite", bus.RegWrite, 1);
      chk("alu7_rd", bus.rd, 7);
      chk("alu7_data", bus.WriteData, 32'hDEADBEEF);
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h1111;
      step();
      idle();
      #1 chk("alu0_regwrite", bus.RegWrite, 0);
      step();

      // Slow path and scoreboard
      bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
      step();
      idle();
      bus.chk_rs2 = 5'd9;
      #1 chk("issue9_stall", bus.stall, 1);
      bus.mem_valid = 1'b1; bus.mem_rd = 5'd9; bus.mem_data = 32'h1234;
      step();
      idle();
      bus.chk_rs2 = 5'd9;
      step();
      idle();
      bus.chk_rs2 = 5'd9;
      #1;
      chk("slow9_regwrite", bus.RegWrite, 1);
      chk("slow9_rd", bus.rd, 9);
      chk("slow9_data", bus.WriteData, 32'h1234);
      chk("slow9_stall_clear", bus.stall, 0);
      step();

      // Full FIFO under continuous ALU traffic
      for (int i = 0; i < 4; i++) begin
         idle();
         bus.issue_valid = 1'b1; bus.issue_rd = 5'(10 + i);
         step();
      end
      idle();
      for (int i = 0; i < 4; i++) begin
         bus.alu_valid = 1'b1; bus.alu_rd = 5'(20 + i); bus.alu_data = $urandom;
         bus.mem_valid = 1'b1; bus.mem_rd = 5'(10 + i); bus.mem_data = $urandom;
         step();
      end
      bus.mem_valid = 1'b0;
      bus.alu_rd = 5'd24; bus.alu_data = $urandom;
      #1;
      chk("full_count", bus.fifo_count, 4);
      chk("full_alu_ready", bus.alu_ready, 0);
      chk("full_mem_ready", bus.mem_ready, 0);
      step();
      #1 chk("reopen_alu_ready", bus.alu_ready, 1);
      step();
      bus.alu_rd = 5'd25; bus.alu_data = $urandom;
      step();
      idle();
      repeat (6) step();

      // Set/clear collision on rd 3
      bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
      step();
      idle();
      bus.mem_valid = 1'b1; bus.mem_rd = 5'd3; bus.mem_data = 32'hAB;
      step();
      idle();
      bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
      step();
      idle();
      bus.chk_rs1 = 5'd3;
      #1 chk("collision_stall", bus.stall, 1);
      step();

      // Bypass
      idle();
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h55;
      step();
      idle();
`ifdef WB_BYPASS_EN
      bus.chk_rs1 = 5'd4;
      #1;
      chk("byp4_hit1", bus.byp_hit1, 1);
      chk("byp4_data", bus.byp_data, 32'h55);
      bus.chk_rs1 = 5'd0;
      #1 chk("byp0_hit1", bus.byp_hit1, 0);
`endif
      step();

      // Reset mid-stream with 3 entries queued and rd 5 pending
      bus.issue_valid = 1'b1; bus.issue_rd = 5'd5;
      step();
      idle();
      for (int i = 0; i < 3; i++) begin
         bus.alu_valid = 1'b1; bus.alu_rd = 5'(21 + i); bus.alu_data = $urandom;
         bus.mem_valid = 1'b1; bus.mem_rd = 5'(14 + i); bus.mem_data = $urandom;
         step();
      end
      bus.mem_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_fifo_count", bus.fifo_count, 0);
      chk("midrst_regwrite", bus.RegWrite, 0);
      chk("midrst_mem_ready", bus.mem_ready, 1);
      model_reset();
      idle();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus.chk_rs1 = 5'd5;
      #1 chk("postrst_stall5", bus.stall, 0);
      step();

      // Random traffic with legal upstream behaviour
      for (int n = 0; n < 1500; n++) begin
         if (!alu_hold) begin
            bus.alu_valid = ($urandom % 3 == 0);
            bus.alu_rd    = 5'($urandom);
            bus.alu_data  = $urandom;
         end
         if (!mem_hold) begin
            if (inflight.size() > 0 && ($urandom % 2 == 1)) begin
               bus.mem_valid = 1'b1;
               bus.mem_rd    = inflight.pop_front();
               bus.mem_data  = $urandom;
            end else begin
               bus.mem_valid = 1'b0;
            end
         end
         r = 5'($urandom);
         bus.issue_valid = 1'b0;
         bus.issue_rd    = r;
         if (($urandom % 4 == 0) && !pend[r]) begin
            bus.issue_valid = 1'b1;
            inflight.push_back(r);
         end
         bus.chk_rs1 = 5'($urandom);
         bus.chk_rs2 = 5'($urandom);
         bus.chk_rd  = 5'($urandom);
         step();
      end

      // Drain remaining slow results
      for (int n = 0; n < 300; n++) begin
         bus.alu_valid   = 1'b0;
         bus.issue_valid = 1'b0;
         if (!mem_hold) begin
            if (inflight.size() > 0) begin
               bus.mem_valid = 1'b1;
               bus.mem_rd    = inflight.pop_front();
               bus.mem_data  = $urandom;
            end else begin
               bus.mem_valid = 1'b0;
            end
         end
         if (!bus.mem_valid && inflight.size() == 0 && mq.size() == 0 && exp_q.size() == 0)
            break;
         step();
      end
      idle();
      repeat (3) step();
      chk("drain_exp_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
